// File: rtl/bin_to_7seghex_if.sv
// Nibble-in / segments-out bundle for one seven-segment hex digit.
// The master drives the nibble bits a0 (MSB) .. a3 (LSB); the slave returns
// the seven segment lines L0 (segment a) .. L6 (segment g).
interface bin_to_7seghex_if;
  logic a0;
  logic a1;
  logic a2;
  logic a3;
  logic L0;
  logic L1;
  logic L2;
  logic L3;
  logic L4;
  logic L5;
  logic L6;

  modport master (
    output a0, a1, a2, a3,
    input  L0, L1, L2, L3, L4, L5, L6
  );

  modport slave (
    input  a0, a1, a2, a3,
    output L0, L1, L2, L3, L4, L5, L6
  );
endinterface

// File: rtl/bin_to_7seghex.sv
// Registered 4-bit binary to 7-segment hexadecimal decoder.
// Glyphs 0-9, A, b, C, d, E, F; segment vector is {g,f,e,d,c,b,a} = L6..L0.
// Outputs are registered so the display lines never glitch.
// Build option: define BIN_TO_7SEGHEX_ACTIVE_LOW_EN for common-anode displays
// (every segment inverted, blank digit becomes 7'h7F).
module bin_to_7seghex (
  input logic             clk,
  input logic             rst_n,
  bin_to_7seghex_if.slave bus
);

  // Glyph table in active-high form; index is the nibble value.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      // Only reachable in simulation when an input is X or Z: blank the digit.
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

`ifdef BIN_TO_7SEGHEX_ACTIVE_LOW_EN
  // Common-anode build: a segment lights when its line is low.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] drive_level(input logic [6:0] seg_on);
    return ~seg_on;
  endfunction
`else
  // Common-cathode build: a segment lights when its line is high.
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] drive_level(input logic [6:0] seg_on);
    return seg_on;
  endfunction
`endif

  logic [3:0] nib_p0;
  logic [6:0] seg_p0;
  logic [6:0] seg_p1;

  // Stage p0: assemble the nibble (a0 is the MSB) and decode combinationally.
  assign nib_p0 = {bus.a0, bus.a1, bus.a2, bus.a3};

  // Decode the nibble and apply the output polarity of this build.
  always_comb begin
    seg_p0 = drive_level(hex_glyph(nib_p0));
  end

  // Stage p1: glitch-free output register; reset blanks the digit on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_p1 <= SEG_OFF;
    end else begin
      seg_p1 <= seg_p0;
    end
  end

  assign bus.L0 = seg_p1[0];
  assign bus.L1 = seg_p1[1];
  assign bus.L2 = seg_p1[2];
  assign bus.L3 = seg_p1[3];
  assign bus.L4 = seg_p1[4];
  assign bus.L5 = seg_p1[5];
  assign bus.L6 = seg_p1[6];

endmodule

// File: tb/tb_bin_to_7seghex.sv
// Testbench for bin_to_7seghex: directed steps plus randomized nibbles/resets
// checked against a table-driven model of the digit glyphs.
// Honours BIN_TO_7SEGHEX_ACTIVE_LOW_EN the same way as the design build.
module tb_bin_to_7seghex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bin_to_7seghex_if bus ();

  bin_to_7seghex dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Lit-segment pattern for each hex digit, {g,f,e,d,c,b,a}.
  logic [6:0] glyph_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference: what the display lines should carry for a lit pattern.
  function automatic logic [6:0] lines_for(input logic [6:0] lit);
`ifdef BIN_TO_7SEGHEX_ACTIVE_LOW_EN
    return 7'h7F ^ lit;
`else
    return lit;
`endif
  endfunction

  function automatic logic [6:0] expect_after_edge(input int n, input logic rst_val);
    if (rst_val == 1'b0) return lines_for(7'h00);
    return lines_for(glyph_tbl[n]);
  endfunction

  function automatic logic [6:0] observed();
    return {bus.L6, bus.L5, bus.L4, bus.L3, bus.L2, bus.L1, bus.L0};
  endfunction

  task automatic drive_nib(input int n);
    bus.a0 = n[3];
    bus.a1 = n[2];
    bus.a2 = n[1];
    bus.a3 = n[0];
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later and compare.
  task automatic step(input string tag, input int n, input logic rst_val);
    rst_n = rst_val;
    drive_nib(n);
    @(posedge clk);
    #1;
    check(tag, expect_after_edge(n, rst_val));
  endtask

  initial begin
    int n;
    logic r;
    drive_nib(8);

    // Reset held for two edges with N=8.
    step("reset_edge1", 8, 1'b0);
    step("reset_edge2", 8, 1'b0);

    // Full sweep, one value per cycle.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep_%0d", i), i, 1'b1);
    end

    // Bit order: a0 alone is the MSB (8), a3 alone is the LSB (1).
    rst_n = 1'b1;
    bus.a0 = 1'b1; bus.a1 = 1'b0; bus.a2 = 1'b0; bus.a3 = 1'b0;
    @(posedge clk); #1;
    check("bitorder_a0", lines_for(7'h7F));
    bus.a0 = 1'b0; bus.a1 = 1'b0; bus.a2 = 1'b0; bus.a3 = 1'b1;
    @(posedge clk); #1;
    check("bitorder_a3", lines_for(7'h06));

    // Mid-stream reset with N=A.
    step("midrst_pre", 10, 1'b1);
    step("midrst_low", 10, 1'b0);
    step("midrst_rel", 10, 1'b1);

    // Hold and glitch: toggle 7/1 between edges, settled at 7 before each edge.
    step("hold_load", 7, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1; drive_nib(1); #1; check("hold_mid_a", lines_for(7'h07));
      #1; drive_nib(7); #1; check("hold_mid_b", lines_for(7'h07));
      #1; drive_nib(1); #1; check("hold_mid_c", lines_for(7'h07));
      drive_nib(7);
      @(posedge clk); #1;
      check("hold_edge", lines_for(7'h07));
    end

    // Randomized nibbles with occasional reset pulses.
    for (int i = 0; i < 60; i++) begin
      n = int'($urandom_range(0, 15));
      r = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      step("random", n, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
